memory_stage: RTL and testbench

Pipeline stage directly downstream of the Execution stage. It consumes the ALU result (used as the effective address for memory ops), the destination register and the store data. It performs byte/word loads and stores through a ready-handshaked data-memory port, stalling upstream for multi-cycle accesses. Its registered output feeds writeback and the mem-level bypass inputs (bp_data_mem/bp_reg_mem) of Execution.

---
 rtl/memory_stage.sv | 161 ++++++++++++++++
 tb/tb_memory_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: byte/word loads and stores over a ready-handshaked data port,
// stalling upstream while an access is in flight, with misalignment and timeout detection.
module memory_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [6:0]  OP_LDB  = 7'h10,
  parameter logic [6:0]  OP_LDW  = 7'h11,
  parameter logic [6:0]  OP_STB  = 7'h12,
  parameter logic [6:0]  OP_STW  = 7'h13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        nop_in,
  input  logic [6:0]  opcode,
  input  logic [31:0] result,
  input  logic [4:0]  dstin,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic [31:0] bp_data_mem,
  output logic [4:0]  bp_reg_mem,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [4:0]  r_dst;
  logic [1:0]  r_lane;
  logic        r_is_byte;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_reg;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_is_mem;
  logic        w_is_word;
  logic        w_is_store;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [31:0] w_load_data;

  always_comb begin
    w_is_mem    = (opcode == OP_LDB) || (opcode == OP_LDW) ||
                  (opcode == OP_STB) || (opcode == OP_STW);
    w_is_word   = (opcode == OP_LDW) || (opcode == OP_STW);
    w_is_store  = (opcode == OP_STB) || (opcode == OP_STW);
    w_misalign  = w_is_word && (result[1:0] != 2'b00);
    w_be        = w_is_word ? 4'hF : (4'b0001 << result[1:0]);
    w_wdata     = w_is_word ? store_data : {4{store_data[7:0]}};
    w_byte      = '0;
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_load_data = r_is_byte ? {{24{w_byte[7]}}, w_byte} : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dst      <= '0;
      r_lane     <= '0;
      r_is_byte  <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_reg   <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && !nop_in) begin
            if (!w_is_mem) begin
              r_wb_data  <= result;
              r_wb_reg   <= dstin;
              r_wb_valid <= (dstin != 5'd0);
            end else if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_req     <= 1'b1;
              r_we      <= w_is_store;
              r_addr    <= {result[31:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_dst     <= dstin;
              r_lane    <= result[1:0];
              r_is_byte <= !w_is_word;
              r_cnt     <= '0;
              r_state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Completion wins over a timeout landing on the same cycle.
          if (mem_ready) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
            if (!r_we) begin
              r_wb_valid <= (r_dst != 5'd0);
              r_wb_reg   <= r_dst;
              r_wb_data  <= w_load_data;
            end
          end else if (r_cnt == 5'(TIMEOUT - 1)) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall        = (r_state == ACCESS);
  assign mem_req      = r_req;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_be       = r_be;
  assign mem_wdata    = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_reg       = r_wb_reg;
  assign bp_data_mem  = r_wb_data;
  assign bp_reg_mem   = r_wb_valid ? r_wb_reg : 5'd0;
  assign misalign_err = r_misalign;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: writebacks are predicted into a queue and popped as they appear.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset, enable, nop_in;
  logic [6:0]  opcode;
  logic [31:0] result, store_data, mem_rdata;
  logic [4:0]  dstin;
  logic        mem_ready;
  logic        stall, mem_req, mem_we, wb_valid, misalign_err, timeout_err;
  logic [31:0] mem_addr, mem_wdata, wb_data, bp_data_mem;
  logic [3:0]  mem_be;
  logic [4:0]  wb_reg, bp_reg_mem;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  memory_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .nop_in(nop_in),
    .opcode(opcode), .result(result), .dstin(dstin), .store_data(store_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg(wb_reg), .bp_data_mem(bp_data_mem), .bp_reg_mem(bp_reg_mem),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then retire any writeback against the scoreboard.
  task automatic step();
    wb_t e;
    @(posedge clk);
    #1;
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {31'b0, wb_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_reg", {27'b0, wb_reg}, {27'b0, e.rd});
        chk("bp_reg_mem", {27'b0, bp_reg_mem}, {27'b0, e.rd});
        chk("bp_data_mem", bp_data_mem, e.data);
      end
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] res,
                       input logic [4:0] rd, input logic [31:0] sd);
    enable = 1'b1; nop_in = 1'b0; opcode = op; result = res; dstin = rd; store_data = sd;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; opcode = 7'h00; result = '0; dstin = '0; store_data = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; nop_in = 1'b0; opcode = '0; result = '0;
    dstin = '0; store_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_errs", {30'b0, misalign_err, timeout_err}, 32'd0);
    reset = 1'b0;

    // ALU pass-through, single-cycle latency
    issue(7'h00, 32'd30, 5'd3, '0);
    exp_q.push_back('{rd: 5'd3, data: 32'd30});
    step();
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    idle_inputs();
    step();
    chk("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("bubble_bp_reg", {27'b0, bp_reg_mem}, 32'd0);

    // nop_in bubble
    issue(7'h00, 32'd99, 5'd4, '0); nop_in = 1'b1;
    step();
    chk("nop_wb_valid", {31'b0, wb_valid}, 32'd0);

    // Back-to-back ALU ops; r0 destination produces no writeback
    issue(7'h05, 32'h1111, 5'd5, '0);
    exp_q.push_back('{rd: 5'd5, data: 32'h1111});
    step();
    chk("b2b0_wb_valid", {31'b0, wb_valid}, 32'd1);
    issue(7'h06, 32'h2222, 5'd0, '0);
    step();
    chk("b2b1_wb_valid", {31'b0, wb_valid}, 32'd0);
    issue(7'h07, 32'h3333, 5'd7, '0);
    exp_q.push_back('{rd: 5'd7, data: 32'h3333});
    step();
    chk("b2b2_wb_valid", {31'b0, wb_valid}, 32'd1);

    // LDW with three wait cycles; upstream garbage must be ignored
    issue(7'h11, 32'h100, 5'd8, '0);
    step();
    chk("ldw_req", {31'b0, mem_req}, 32'd1);
    chk("ldw_addr", mem_addr, 32'h100);
    chk("ldw_be", {28'b0, mem_be}, 32'hF);
    chk("ldw_we", {31'b0, mem_we}, 32'd0);
    issue(7'h00, 32'h55, 5'd9, '0);
    chk("ldw_stall1", {31'b0, stall}, 32'd1);
    step();
    chk("ldw_stall2", {31'b0, stall}, 32'd1);
    chk("ldw_req_held", {31'b0, mem_req}, 32'd1);
    step();
    chk("ldw_stall3", {31'b0, stall}, 32'd1);
    chk("ldw_addr_held", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    exp_q.push_back('{rd: 5'd8, data: 32'hDEADBEEF});
    step();
    chk("ldw_done_valid", {31'b0, wb_valid}, 32'd1);
    chk("ldw_done_stall", {31'b0, stall}, 32'd0);
    chk("ldw_done_req", {31'b0, mem_req}, 32'd0);
    mem_ready = 1'b0; idle_inputs();
    step();

    // LDB top lane, negative byte
    issue(7'h10, 32'h103, 5'd4, '0);
    step();
    chk("ldb_be", {28'b0, mem_be}, 32'h8);
    chk("ldb_addr", mem_addr, 32'h100);
    idle_inputs();
    mem_ready = 1'b1; mem_rdata = 32'h80FFFFFF;
    exp_q.push_back('{rd: 5'd4, data: 32'hFFFFFF80});
    step();
    chk("ldb_valid", {31'b0, wb_valid}, 32'd1);
    mem_ready = 1'b0;

    // LDB lane 2, positive byte
    issue(7'h10, 32'h2, 5'd12, '0);
    step();
    chk("ldb2_be", {28'b0, mem_be}, 32'h4);
    idle_inputs();
    mem_ready = 1'b1; mem_rdata = 32'h11227F33;
    exp_q.push_back('{rd: 5'd12, data: 32'h00000022});
    step();
    mem_ready = 1'b0;

    // STB lane 1
    issue(7'h12, 32'h201, 5'd6, 32'h000000AB);
    step();
    chk("stb_we", {31'b0, mem_we}, 32'd1);
    chk("stb_be", {28'b0, mem_be}, 32'h2);
    chk("stb_wdata", mem_wdata, 32'hABABABAB);
    chk("stb_addr", mem_addr, 32'h200);
    idle_inputs();
    mem_ready = 1'b1;
    step();
    chk("stb_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("stb_req_drop", {31'b0, mem_req}, 32'd0);
    mem_ready = 1'b0;

    // STW aligned: full word and byte enables
    issue(7'h13, 32'h204, 5'd6, 32'hCAFEF00D);
    step();
    chk("stw_be", {28'b0, mem_be}, 32'hF);
    chk("stw_wdata", mem_wdata, 32'hCAFEF00D);
    idle_inputs();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;

    // STW misaligned
    issue(7'h13, 32'h202, 5'd6, 32'h12345678);
    step();
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    chk("mis_wb_valid", {31'b0, wb_valid}, 32'd0);
    idle_inputs();
    step();
    chk("mis_pulse_end", {31'b0, misalign_err}, 32'd0);

    // Timeout after 16 cycles in ACCESS
    issue(7'h11, 32'h300, 5'd9, '0);
    step();
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      chk("to_stall", {31'b0, stall}, 32'd1);
      step();
    end
    chk("to_still_waiting", {31'b0, stall}, 32'd1);
    step();
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    chk("to_req", {31'b0, mem_req}, 32'd0);
    chk("to_stall_end", {31'b0, stall}, 32'd0);
    chk("to_wb_valid", {31'b0, wb_valid}, 32'd0);
    step();
    chk("to_pulse_end", {31'b0, timeout_err}, 32'd0);

    // mem_ready on the final cycle beats timeout
    issue(7'h11, 32'h304, 5'd10, '0);
    step();
    idle_inputs();
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    exp_q.push_back('{rd: 5'd10, data: 32'h12345678});
    step();
    chk("prio_no_timeout", {31'b0, timeout_err}, 32'd0);
    chk("prio_wb_valid", {31'b0, wb_valid}, 32'd1);
    mem_ready = 1'b0;

    // mem_ready while IDLE is ignored
    mem_ready = 1'b1;
    step();
    chk("idle_ready_ignored", {31'b0, wb_valid}, 32'd0);
    mem_ready = 1'b0;

    // Reset during ACCESS discards the access
    issue(7'h11, 32'h400, 5'd11, '0);
    step();
    chk("rsta_req", {31'b0, mem_req}, 32'd1);
    idle_inputs();
    reset = 1'b1;
    step();
    chk("rsta_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rsta_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rsta_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
    step();
    chk("rsta_late_ready", {31'b0, wb_valid}, 32'd0);
    mem_ready = 1'b0;
    step();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
